// File: rtl/cart_drive_decoder_if.sv
// rtl/cart_drive_decoder_if.sv - command and motor/horn drive bundle for cart_drive_decoder
//
// Purpose: carries the game-state/command inputs and the registered H-bridge,
//          PWM and buzzer outputs between the game controller and the decoder.
// Signals:
//   state[2:0]          game FSM state (RACING = 4)
//   operation_code[2:0] NIL/FORWARD/BACKWARD/LEFT/RIGHT (5-7 read as NIL)
//   boost, honk         speed-up and horn requests
//   ain1, ain2          left motor direction bits
//   bin1, bin2          right motor direction bits
//   pwm_a, pwm_b        motor enable PWM (identical)
//   buzzer              horn square wave
//   duty[7:0]           currently applied duty
// Modports: master drives commands and observes outputs; slave is the decoder.
interface cart_drive_decoder_if;
    logic [2:0] state;
    logic [2:0] operation_code;
    logic       boost;
    logic       honk;
    logic       ain1;
    logic       ain2;
    logic       bin1;
    logic       bin2;
    logic       pwm_a;
    logic       pwm_b;
    logic       buzzer;
    logic [7:0] duty;

    modport master (
        output state, operation_code, boost, honk,
        input  ain1, ain2, bin1, bin2, pwm_a, pwm_b, buzzer, duty
    );

    modport slave (
        input  state, operation_code, boost, honk,
        output ain1, ain2, bin1, bin2, pwm_a, pwm_b, buzzer, duty
    );
endinterface

// File: rtl/cart_drive_decoder.sv
// rtl/cart_drive_decoder.sv - cart motor direction/PWM ramp decoder with dead phase and horn
//
// Purpose: turns the game state and driver command into H-bridge direction
//          bits, a ramped PWM duty and a square-wave horn.
// Ports:
//   clk  system clock, all state on the rising edge
//   rst  synchronous active-high reset
//   bus  cart_drive_decoder_if.slave (commands in, registered drive out)
module cart_drive_decoder #(
    parameter int         RAMP_DIV     = 100000,
    parameter int         RAMP_STEP    = 8,
    parameter int         DEAD_CYCLES  = 50000,
    parameter logic [7:0] CRUISE_DUTY  = 8'd160,
    parameter logic [7:0] BOOST_DUTY   = 8'd240,
    parameter logic [7:0] REVERSE_DUTY = 8'd128,
    parameter logic [7:0] TURN_DUTY    = 8'd120,
    parameter int         HONK_HOLD    = 25000000,
    parameter int         TONE_HALF    = 113636
) (
    input  logic                 clk,
    input  logic                 rst,
    cart_drive_decoder_if.slave  bus
);

    localparam int RAMP_W = $clog2(RAMP_DIV);
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam int HONK_W = $clog2(HONK_HOLD + 1);
    localparam int TONE_W = $clog2(TONE_HALF + 1);

    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES);
    localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);
    localparam logic [HONK_W-1:0] HONK_LOAD = HONK_W'(HONK_HOLD);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
    localparam logic [8:0]        STEP9     = 9'(RAMP_STEP);

    localparam logic [2:0] OP_NIL   = 3'd0;
    localparam logic [2:0] OP_FWD   = 3'd1;
    localparam logic [2:0] OP_BWD   = 3'd2;
    localparam logic [2:0] OP_LEFT  = 3'd3;
    localparam logic [2:0] OP_RIGHT = 3'd4;
    localparam logic [2:0] ST_RACING = 3'd4;

    typedef enum logic [1:0] {
        S_STOP = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } fsm_t;

    fsm_t              fsm, fsm_next;
    logic [2:0]        dir, dir_next;
    logic [DEAD_W-1:0] dead_cnt, dead_next;
    logic [7:0]        duty_q, duty_next;
    logic [RAMP_W-1:0] ramp_cnt;
    logic [7:0]        pwm_cnt, pwm_cnt_next;
    logic [3:0]        dir_bits_q, dir_bits_next;
    logic              pwm_q;
    logic [HONK_W-1:0] honk_tmr, honk_next;
    logic [TONE_W-1:0] tone_cnt, tone_next;
    logic              buz_q, buz_next;

    logic [2:0]        op;
    logic              racing;
    logic              tick;
    logic [7:0]        target;
    logic [7:0]        ramped;
    logic [8:0]        up_sum;

    // Unused opcodes collapse to NIL so they can never start the motors.
    assign op     = (bus.operation_code > OP_RIGHT) ? OP_NIL : bus.operation_code;
    assign racing = (bus.state == ST_RACING);
    assign tick   = (ramp_cnt == RAMP_LAST);
    assign pwm_cnt_next = pwm_cnt + 8'd1;

    // Target duty follows the latched direction; boost only matters going forward.
    always_comb begin
        target = 8'd0;
        case (dir)
            OP_FWD:   target = bus.boost ? BOOST_DUTY : CRUISE_DUTY;
            OP_BWD:   target = REVERSE_DUTY;
            OP_LEFT,
            OP_RIGHT: target = TURN_DUTY;
            default:  target = 8'd0;
        endcase
    end

    // One ramp step toward target, computed in 9 bits and clamped so it never overshoots.
    always_comb begin
        up_sum = {1'b0, duty_q} + STEP9;
        ramped = duty_q;
        if (duty_q < target) begin
            ramped = (up_sum >= {1'b0, target}) ? target : up_sum[7:0];
        end else if (duty_q > target) begin
            ramped = ({1'b0, duty_q} >= ({1'b0, target} + STEP9)) ? (duty_q - STEP9[7:0]) : target;
        end
    end

    // Motor FSM next state. Leaving RACING wins over every other transition.
    always_comb begin
        fsm_next  = fsm;
        dir_next  = dir;
        dead_next = dead_cnt;
        duty_next = duty_q;
        if (!racing) begin
            fsm_next  = S_STOP;
            duty_next = 8'd0;
            dead_next = '0;
        end else begin
            case (fsm)
                S_STOP: begin
                    duty_next = 8'd0;
                    if (op != OP_NIL) begin
                        dir_next = op;
                        fsm_next = S_RUN;
                    end
                end
                S_RUN: begin
                    if (op != dir) begin
                        fsm_next  = S_DEAD;
                        dead_next = DEAD_LOAD;
                        duty_next = 8'd0;
                    end else if (tick) begin
                        duty_next = ramped;
                    end
                end
                S_DEAD: begin
                    duty_next = 8'd0;
                    if (dead_cnt <= DEAD_ONE) begin
                        dead_next = '0;
                        if (op != OP_NIL) begin
                            dir_next = op;
                            fsm_next = S_RUN;
                        end else begin
                            fsm_next = S_STOP;
                        end
                    end else begin
                        dead_next = dead_cnt - 1'b1;
                    end
                end
                default: begin
                    fsm_next  = S_STOP;
                    duty_next = 8'd0;
                end
            endcase
        end
    end

    // Direction bits are registered from the next state so they change on the
    // same edge that latches a direction or enters the dead phase.
    always_comb begin
        dir_bits_next = 4'b0000;
        if (fsm_next == S_RUN) begin
            case (dir_next)
                OP_FWD:   dir_bits_next = 4'b1010;
                OP_BWD:   dir_bits_next = 4'b0101;
                OP_LEFT:  dir_bits_next = 4'b0110;
                OP_RIGHT: dir_bits_next = 4'b1001;
                default:  dir_bits_next = 4'b0000;
            endcase
        end
    end

    // Horn: hold timer plus tone divider. The tone is gated on the next timer
    // value so the buzzer is low in exactly the cycles where the timer is zero.
    always_comb begin
        honk_next = honk_tmr;
        tone_next = tone_cnt;
        buz_next  = buz_q;
        if (!racing) begin
            honk_next = '0;
        end else if (bus.honk) begin
            honk_next = HONK_LOAD;
        end else if (honk_tmr != '0) begin
            honk_next = honk_tmr - 1'b1;
        end

        if (honk_next == '0) begin
            tone_next = '0;
            buz_next  = 1'b0;
        end else if (tone_cnt >= TONE_LAST) begin
            tone_next = '0;
            buz_next  = ~buz_q;
        end else begin
            tone_next = tone_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= S_STOP;
            dir        <= OP_NIL;
            dead_cnt   <= '0;
            duty_q     <= 8'd0;
            ramp_cnt   <= '0;
            pwm_cnt    <= 8'd0;
            dir_bits_q <= 4'b0000;
            pwm_q      <= 1'b0;
            honk_tmr   <= '0;
            tone_cnt   <= '0;
            buz_q      <= 1'b0;
        end else begin
            fsm        <= fsm_next;
            dir        <= dir_next;
            dead_cnt   <= dead_next;
            duty_q     <= duty_next;
            ramp_cnt   <= tick ? '0 : ramp_cnt + 1'b1;
            pwm_cnt    <= pwm_cnt_next;
            dir_bits_q <= dir_bits_next;
            pwm_q      <= (pwm_cnt_next < duty_next);
            honk_tmr   <= honk_next;
            tone_cnt   <= tone_next;
            buz_q      <= buz_next;
        end
    end

    assign bus.ain1   = dir_bits_q[3];
    assign bus.ain2   = dir_bits_q[2];
    assign bus.bin1   = dir_bits_q[1];
    assign bus.bin2   = dir_bits_q[0];
    assign bus.pwm_a  = pwm_q;
    assign bus.pwm_b  = pwm_q;
    assign bus.buzzer = buz_q;
    assign bus.duty   = duty_q;

endmodule

// File: tb/tb_cart_drive_decoder.sv
// tb/tb_cart_drive_decoder.sv - scoreboard bench for cart_drive_decoder
module tb_cart_drive_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cart_drive_decoder_if bus();

    cart_drive_decoder #(
        .RAMP_DIV     (4),
        .RAMP_STEP    (40),
        .DEAD_CYCLES  (3),
        .CRUISE_DUTY  (8'd160),
        .BOOST_DUTY   (8'd240),
        .REVERSE_DUTY (8'd128),
        .TURN_DUTY    (8'd120),
        .HONK_HOLD    (10),
        .TONE_HALF    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_fsm, m_dir, m_dcnt, m_duty, m_ramp, m_pwm, m_tmr, m_tone, m_buz;
    logic [31:0] exp_q[$];
    int seen[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dirs();
        return 32'({bus.ain1, bus.ain2, bus.bin1, bus.bin2});
    endfunction

    function automatic logic [31:0] observed();
        return {17'd0, bus.ain1, bus.ain2, bus.bin1, bus.bin2,
                bus.pwm_a, bus.pwm_b, bus.buzzer, bus.duty};
    endfunction

    function automatic int target_of(input int d, input logic b);
        if (d == 1) return b ? 240 : 160;
        if (d == 2) return 128;
        if (d == 3 || d == 4) return 120;
        return 0;
    endfunction

    function automatic int approach(input int d, input int t);
        if (d < t) return (d + 40 > t) ? t : d + 40;
        if (d > t) return (d - 40 < t) ? t : d - 40;
        return d;
    endfunction

    function automatic logic [3:0] dir_map(input int d);
        case (d)
            1: return 4'b1010;
            2: return 4'b0101;
            3: return 4'b0110;
            4: return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    // Advances the model by one clock edge using the inputs now on the bus
    // and queues the outputs expected just after that edge.
    task automatic model_edge();
        int st, opd;
        bit tick;
        logic [3:0] db;
        logic pw;
        st  = int'(bus.state);
        opd = int'(bus.operation_code);
        if (opd > 4) opd = 0;
        if (rst) begin
            m_fsm = 0; m_dir = 0; m_dcnt = 0; m_duty = 0; m_ramp = 0;
            m_pwm = 0; m_tmr = 0; m_tone = 0; m_buz = 0;
        end else begin
            tick   = (m_ramp == 3);
            m_ramp = tick ? 0 : m_ramp + 1;
            m_pwm  = (m_pwm + 1) % 256;
            if (st != 4) begin
                m_fsm = 0; m_duty = 0;
            end else if (m_fsm == 0) begin
                if (opd != 0) begin m_dir = opd; m_fsm = 1; end
            end else if (m_fsm == 1) begin
                if (opd != m_dir) begin
                    m_fsm = 2; m_dcnt = 3; m_duty = 0;
                end else if (tick) begin
                    m_duty = approach(m_duty, target_of(m_dir, bus.boost));
                end
            end else begin
                if (m_dcnt == 1) begin
                    if (opd != 0) begin m_dir = opd; m_fsm = 1; end
                    else m_fsm = 0;
                end else begin
                    m_dcnt--;
                end
            end
            if (st != 4) m_tmr = 0;
            else if (bus.honk) m_tmr = 10;
            else if (m_tmr > 0) m_tmr--;
            if (m_tmr == 0) begin
                m_tone = 0; m_buz = 0;
            end else if (m_tone == 1) begin
                m_tone = 0; m_buz = 1 - m_buz;
            end else begin
                m_tone++;
            end
        end
        db = (m_fsm == 1) ? dir_map(m_dir) : 4'b0000;
        pw = (m_pwm < m_duty);
        exp_q.push_back({17'd0, db, pw, pw, m_buz[0], 8'(m_duty)});
    endtask

    task automatic step(input string tag);
        logic [31:0] e;
        model_edge();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val(tag, observed(), e);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Steps n cycles and records every new duty value seen.
    task automatic run_record(input int n, input string tag);
        int prev;
        seen.delete();
        prev = int'(bus.duty);
        for (int i = 0; i < n; i++) begin
            step(tag);
            if (int'(bus.duty) != prev) begin
                prev = int'(bus.duty);
                seen.push_back(prev);
            end
        end
    endtask

    task automatic check_seq(input string tag, input int v0, input int v1, input int v2, input int v3, input int n);
        int want[4];
        want = '{v0, v1, v2, v3};
        check_val({tag, "_len"}, 32'(seen.size()), 32'(n));
        for (int i = 0; i < n; i++)
            check_val(tag, (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF, 32'(want[i]));
    endtask

    task automatic drive(input int st, input int op, input bit b, input bit h);
        bus.state          = 3'(st);
        bus.operation_code = 3'(op);
        bus.boost          = b;
        bus.honk           = h;
    endtask

    initial begin
        int hi;
        drive(0, 0, 0, 0);
        rst = 1'b1;
        run(2, "reset");
        check_val("reset_duty", 32'(bus.duty), 32'd0);
        rst = 1'b0;

        // forward start and ramp to cruise
        drive(4, 1, 0, 0);
        step("fwd_latch");
        check_val("fwd_dirs", dirs(), 32'hA);
        run_record(19, "fwd_ramp");
        check_seq("fwd_seq", 40, 80, 120, 160, 4);

        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step("pwm_fwd");
            hi += int'(bus.pwm_a);
        end
        check_val("pwm_high_of_256", 32'(hi), 32'd160);

        // boost forward, then reverse ignores boost
        bus.boost = 1'b1;
        run_record(10, "boost");
        check_seq("boost_seq", 200, 240, 0, 0, 2);
        drive(4, 2, 1, 0);
        run(4, "dead_to_bwd");
        run_record(16, "bwd_ramp");
        check_seq("bwd_seq", 40, 80, 120, 128, 4);
        check_val("bwd_dirs", dirs(), 32'h5);
        bus.boost = 1'b0;
        run(4, "bwd_boost_off");
        bus.boost = 1'b1;
        run(4, "bwd_boost_on");
        check_val("bwd_no_dead", 32'(bus.duty), 32'd128);

        // forward to left through the dead phase
        drive(4, 1, 0, 0);
        run(24, "refwd");
        drive(4, 3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("left_dead");
            check_val("dead_dirs", dirs(), 32'h0);
            check_val("dead_duty", 32'(bus.duty), 32'd0);
        end
        step("left_exit");
        check_val("left_dirs", dirs(), 32'h6);
        run_record(16, "left_ramp");
        check_seq("left_seq", 40, 80, 120, 0, 3);

        // pause stops immediately, resume ramps from zero
        drive(5, 1, 0, 0);
        step("pause");
        check_val("pause_dirs", dirs(), 32'h0);
        check_val("pause_duty", 32'(bus.duty), 32'd0);
        run(4, "paused");
        drive(4, 1, 0, 0);
        step("resume");
        check_val("resume_dirs", dirs(), 32'hA);
        check_val("resume_duty", 32'(bus.duty), 32'd0);
        run(8, "resume_ramp");

        // one-cycle honk while racing
        drive(4, 0, 0, 1);
        step("honk_pulse");
        hi = int'(bus.buzzer);
        bus.honk = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step("honk_tone");
            hi += int'(bus.buzzer);
        end
        check_val("honk_high_cycles", 32'(hi), 32'd5);
        check_val("honk_end", 32'(bus.buzzer), 32'd0);

        // honk outside racing is ignored
        drive(0, 0, 0, 1);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            step("honk_idle");
            hi += int'(bus.buzzer);
        end
        check_val("honk_idle_high", 32'(hi), 32'd0);

        // opcode 6 reads as NIL
        drive(4, 6, 0, 0);
        run(6, "op6");
        check_val("op6_dirs", dirs(), 32'h0);
        check_val("op6_duty", 32'(bus.duty), 32'd0);

        // reset in the middle of a dead phase with the horn sounding
        drive(4, 1, 0, 0);
        run(6, "pre_rst_run");
        bus.honk = 1'b1;
        step("pre_rst_honk");
        drive(4, 4, 0, 0);
        step("pre_rst_dead");
        step("pre_rst_dead2");
        rst = 1'b1;
        step("rst_mid");
        check_val("rst_mid_all", observed(), 32'h0);
        rst = 1'b0;
        drive(0, 0, 0, 0);
        run(2, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cart_drive_decoder.md
CART_DRIVE_DECODER -- requirements
Module: cart_drive_decoder

Interface
REQ-001 Parameter RAMP_DIV, 100000, clock cycles per duty-ramp tick (>=2).
REQ-002 Parameter RAMP_STEP, 8, duty increment/decrement per ramp tick (1..255).
REQ-003 Parameter DEAD_CYCLES, 50000, length of the direction-change dead phase in cycles (>=1).
REQ-004 Parameter CRUISE_DUTY / BOOST_DUTY / REVERSE_DUTY / TURN_DUTY, 160 / 240 / 128 / 120, 8-bit target duties.
REQ-005 Parameter HONK_HOLD, 25000000, buzzer hold time after the last honk-high cycle (>=1).
REQ-006 Parameter TONE_HALF, 113636, buzzer half-period in cycles (>=1).
REQ-007 clk  input  1  system clock; all state updates on the rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 state  input  3  game FSM state (IDLE=0, SETTING=1, SYNCING=2, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6).
REQ-010 operation_code  input  3  NIL=0, FORWARD=1, BACKWARD=2, LEFT=3, RIGHT=4; codes 5-7 SHALL be treated as NIL.
REQ-011 boost  input  1  speed-up request.
REQ-012 honk  input  1  honk request.
REQ-013 ain1, ain2, bin1, bin2  output  1 each  H-bridge direction bits for the left (a) and right (b) motors, registered.
REQ-014 pwm_a, pwm_b  output  1 each  motor enable PWM, identical waveforms, registered.
REQ-015 buzzer  output  1  square-wave horn drive, registered.
REQ-016 duty  output  8  current applied duty, registered.

Function
REQ-017 FSM states SHALL be S_STOP, S_RUN and S_DEAD; every direction, PWM and buzzer output SHALL be driven from registers.
REQ-018 S_STOP: all direction bits 0, duty 0; if state==RACING and the decoded op is not NIL, the FSM SHALL latch the op as dir and enter S_RUN on the same edge.
REQ-019 Direction bits in S_RUN: FORWARD a=10 b=10; BACKWARD a=01 b=01; LEFT a=01 b=10; RIGHT a=10 b=01 (in1,in2); each SHALL appear the cycle after the latching edge.
REQ-020 S_RUN, decoded op differs from dir (NIL included): the FSM SHALL enter S_DEAD, load the dead counter with DEAD_CYCLES, and clear duty and all direction bits on that edge.
REQ-021 S_DEAD SHALL last exactly DEAD_CYCLES cycles with outputs 0; at exit, a non-NIL op SHALL be latched and the FSM SHALL enter S_RUN at duty 0; a NIL op SHALL enter S_STOP.
REQ-022 Target duty: FORWARD uses BOOST_DUTY if boost==1, otherwise CRUISE_DUTY; BACKWARD uses REVERSE_DUTY; LEFT and RIGHT use TURN_DUTY; boost SHALL be ignored except for FORWARD.
REQ-023 A boost change alone SHALL NOT cause S_DEAD; it only changes the target.
REQ-024 The ramp counter SHALL run freely from 0 to RAMP_DIV-1 and wrap; the wrap cycle is a tick.
REQ-025 In S_RUN, on each tick duty SHALL become min(duty+RAMP_STEP, target) if below target and max(duty-RAMP_STEP, target) if above; arithmetic is 9-bit internally, with no wrap.
REQ-026 The PWM counter SHALL be an 8-bit free-running counter that wraps 255->0; pwm_a = pwm_b = (pwm_cnt < duty), so duty 0 keeps PWM low and duty 255 gives 255 high cycles out of 256.
REQ-027 If state!=RACING in any FSM state, the FSM SHALL enter S_STOP on the next edge, with all motor outputs 0 and duty 0; this has priority over REQ-020/021.
REQ-028 Honk: honk==1 with state==RACING SHALL reload the honk timer with HONK_HOLD; otherwise the timer decrements to 0 and saturates there.
REQ-029 While the timer is nonzero, the tone counter SHALL count 0..TONE_HALF-1 and buzzer SHALL toggle at each wrap.
REQ-030 When the timer is 0, buzzer SHALL be 0 and the tone counter SHALL be 0.
REQ-031 state!=RACING SHALL clear the honk timer on the next edge.
REQ-032 Honk operation SHALL be independent of the motor FSM.

Reset
REQ-033 rst has priority over all other inputs: FSM=S_STOP, dir=NIL, and all counters, timers and outputs 0 on the next edge, including when rst arrives mid-S_DEAD or mid-honk.

Verification (bench parameters RAMP_DIV=4, RAMP_STEP=40, DEAD_CYCLES=3, CRUISE=160, BOOST=240, REVERSE=128, TURN=120, HONK_HOLD=10, TONE_HALF=2)
REQ-034 rst, then state=4 with op=1 held -> a=10 b=10 after 1 cycle; duty steps 40,80,120,160 on successive ticks and holds 160; pwm high for 160 of every 256 cycles.
REQ-035 At duty 160, boost=1 -> duty 200 then 240; with op=2 and boost=1 -> target 128 and no dead phase.
REQ-036 Running op=1, op changes to 3 -> outputs 0 with duty 0 for 3 cycles, then a=01 b=10 and duty ramps 40,80,120.
REQ-037 Running, state changes to 5 -> all motor outputs 0 next cycle, op ignored; state back to 4 with op=1 -> ramp restarts from 0.
REQ-038 One-cycle honk in state 4 -> buzzer toggles every 2 cycles for 10 cycles, then stays 0; honk in state 0 -> buzzer stays 0.
REQ-039 op=6 in state 4 -> stays in S_STOP with all outputs 0; rst during S_DEAD with an active honk -> all outputs 0 next cycle.
